elevator_dispatch: RTL and testbench



---
 rtl/elevator_pkg.sv | 13 +
 rtl/elevator_dispatch_if.sv | 31 +++
 rtl/elevator_tick_timer.sv | 20 ++
 rtl/elevator_dispatch.sv | 171 +++++++++++++++++
 tb/tb_elevator_dispatch.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator dispatch slice.
package elevator_pkg;
  localparam int unsigned FLOOR_DEFAULT = 4;
  localparam int unsigned TIMER_W       = 32;

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN,
    FAULT
  } state_t;
endpackage

// File: rtl/elevator_dispatch_if.sv
// Request inputs and car status outputs between the input stage, the dispatcher and the display/actuator logic.
interface elevator_dispatch_if #(
  parameter int unsigned FLOOR = elevator_pkg::FLOOR_DEFAULT
);
  logic [FLOOR-1:0] queueUp;
  logic [FLOOR-1:0] queueDown;
  logic [FLOOR-1:0] queueinside;
  logic             door_hold;
  logic             fault;
  logic [FLOOR-1:0] cur_floor;
  logic             moving;
  logic             dir_up;
  logic             dir_down;
  logic             door_open;
  logic [FLOOR-1:0] pend_up;
  logic [FLOOR-1:0] pend_down;
  logic [FLOOR-1:0] pend_in;
  logic             alarm;

  modport master (
    output queueUp, queueDown, queueinside, door_hold, fault,
    input  cur_floor, moving, dir_up, dir_down, door_open,
           pend_up, pend_down, pend_in, alarm
  );

  modport slave (
    input  queueUp, queueDown, queueinside, door_hold, fault,
    output cur_floor, moving, dir_up, dir_down, door_open,
           pend_up, pend_down, pend_in, alarm
  );
endinterface

// File: rtl/elevator_tick_timer.sv
// Loadable down-counter; done is high for the single cycle the count sits at 1.
module elevator_tick_timer
  import elevator_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               done
);
  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (load)          count <= value;
    else if (count != '0)   count <= count - TIMER_W'(1);
  end

  assign done = (count == TIMER_W'(1));
endmodule

// File: rtl/elevator_dispatch.sv
// SCAN-policy car controller: latches hall/cabin requests, moves the car and runs the door.
// Optional ELEV_ANTI_PINCH_EN: door_hold keeps reloading the door timer while the door is open.
module elevator_dispatch
  import elevator_pkg::*;
#(
  parameter int unsigned FLOOR      = FLOOR_DEFAULT,
  parameter int unsigned MOVE_TICKS = 400000000,
  parameter int unsigned DOOR_TICKS = 600000000
) (
  input logic                clk,
  input logic                rst,
  elevator_dispatch_if.slave bus
);
  typedef logic [FLOOR-1:0] vec_t;

  state_t state, state_n;
  vec_t   cur, cur_n, pend_u, pend_d, pend_i, pend_all;
  vec_t   mask_lo, mask_hi, nxt_up, nxt_dn, in_mask;
  vec_t   clr_u, clr_d, clr_i;
  logic   pref_up, pref_up_n, above, below, here;
  logic   ahead_up, ahead_dn, stop_up, stop_dn;
  logic   t_load, t_done;
  logic [TIMER_W-1:0] t_value;

  elevator_tick_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (t_load),
    .value (t_value),
    .done  (t_done)
  );

  always_comb begin
    pend_all = pend_u | pend_d | pend_i;
    // cur is one-hot, so cur-1 is exactly the set of floors below it
    mask_lo  = cur - FLOOR'(1);
    mask_hi  = ~(cur | mask_lo);
    above    = |(pend_all & mask_hi);
    below    = |(pend_all & mask_lo);
    here     = |(pend_all & cur);
    nxt_up   = cur << 1;
    nxt_dn   = cur >> 1;
    ahead_up = |(pend_all & ~(nxt_up | (nxt_up - FLOOR'(1))));
    ahead_dn = |(pend_all & (nxt_dn - FLOOR'(1)));
    stop_up  = (|(nxt_up & (pend_i | pend_u))) || (!ahead_up && |(nxt_up & pend_d)) || nxt_up[FLOOR-1];
    stop_dn  = (|(nxt_dn & (pend_i | pend_d))) || (!ahead_dn && |(nxt_dn & pend_u)) || nxt_dn[0];
    in_mask  = (state == DOOR_OPEN) ? cur : '0;
  end

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    pref_up_n = pref_up;
    clr_u     = '0;
    clr_d     = '0;
    clr_i     = '0;
    t_load    = 1'b0;
    t_value   = TIMER_W'(MOVE_TICKS);
    case (state)
      IDLE: begin
        if (here) begin
          state_n = DOOR_OPEN;
          clr_u   = cur;
          clr_d   = cur;
          clr_i   = cur;
          t_load  = 1'b1;
          t_value = TIMER_W'(DOOR_TICKS);
        end else if (above && (pref_up || !below)) begin
          state_n   = MOVE_UP;
          pref_up_n = 1'b1;
          t_load    = 1'b1;
        end else if (below) begin
          state_n   = MOVE_DOWN;
          pref_up_n = 1'b0;
          t_load    = 1'b1;
        end
      end
      MOVE_UP: begin
        if (t_done) begin
          cur_n  = nxt_up;
          t_load = 1'b1;
          if (stop_up) begin
            state_n = DOOR_OPEN;
            clr_i   = nxt_up;
            clr_u   = nxt_up;
            clr_d   = ahead_up ? '0 : nxt_up;
            t_value = TIMER_W'(DOOR_TICKS);
          end
        end
      end
      MOVE_DOWN: begin
        if (t_done) begin
          cur_n  = nxt_dn;
          t_load = 1'b1;
          if (stop_dn) begin
            state_n = DOOR_OPEN;
            clr_i   = nxt_dn;
            clr_d   = nxt_dn;
            clr_u   = ahead_dn ? '0 : nxt_dn;
            t_value = TIMER_W'(DOOR_TICKS);
          end
        end
      end
      DOOR_OPEN: begin
`ifdef ELEV_ANTI_PINCH_EN
        if (bus.door_hold) begin
          t_load  = 1'b1;
          t_value = TIMER_W'(DOOR_TICKS);
        end else if (t_done) begin
          state_n = IDLE;
        end
`else
        if (t_done) state_n = IDLE;
`endif
      end
      FAULT:   if (!bus.fault) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // fault overrides everything, including an arrival on this same edge
    if (bus.fault) begin
      state_n   = FAULT;
      cur_n     = cur;
      pref_up_n = pref_up;
      t_load    = 1'b0;
    end
  end

`ifndef ELEV_ANTI_PINCH_EN
  logic unused_hold;
  assign unused_hold = bus.door_hold;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cur           <= FLOOR'(1);
      pref_up       <= 1'b1;
      pend_u        <= '0;
      pend_d        <= '0;
      pend_i        <= '0;
      bus.moving    <= 1'b0;
      bus.dir_up    <= 1'b0;
      bus.dir_down  <= 1'b0;
      bus.door_open <= 1'b0;
      bus.alarm     <= 1'b0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      pref_up <= pref_up_n;
      if (bus.fault || state == FAULT) begin
        pend_u <= '0;
        pend_d <= '0;
        pend_i <= '0;
      end else begin
        pend_u <= (pend_u | (bus.queueUp     & ~in_mask)) & ~clr_u;
        pend_d <= (pend_d | (bus.queueDown   & ~in_mask)) & ~clr_d;
        pend_i <= (pend_i | (bus.queueinside & ~in_mask)) & ~clr_i;
      end
      bus.moving    <= (state_n == MOVE_UP) || (state_n == MOVE_DOWN);
      bus.dir_up    <= (state_n == MOVE_UP);
      bus.dir_down  <= (state_n == MOVE_DOWN);
      bus.door_open <= (state_n == DOOR_OPEN);
      bus.alarm     <= (state_n == FAULT);
    end
  end

  assign bus.cur_floor = cur;
  assign bus.pend_up   = pend_u;
  assign bus.pend_down = pend_d;
  assign bus.pend_in   = pend_i;
endmodule

// File: tb/tb_elevator_dispatch.sv
// Scoreboard bench for elevator_dispatch (FLOOR=4, MOVE_TICKS=4, DOOR_TICKS=3); honours ELEV_ANTI_PINCH_EN.
module tb_elevator_dispatch;
  localparam int unsigned F = 4;
  localparam int S_CUR = 0, S_MOV = 1, S_UP = 2, S_DN = 3, S_DOOR = 4;
  localparam int S_PUP = 5, S_PDN = 6, S_PIN = 7, S_ALM = 8;

  typedef struct {
    int unsigned at;
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned cyc = 0;
  int unsigned base = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t        sb[$];

  elevator_dispatch_if #(.FLOOR(F)) bus ();

  elevator_dispatch #(
    .FLOOR      (F),
    .MOVE_TICKS (4),
    .DOOR_TICKS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      S_CUR:   return 32'(bus.cur_floor);
      S_MOV:   return 32'(bus.moving);
      S_UP:    return 32'(bus.dir_up);
      S_DN:    return 32'(bus.dir_down);
      S_DOOR:  return 32'(bus.door_open);
      S_PUP:   return 32'(bus.pend_up);
      S_PDN:   return 32'(bus.pend_down);
      S_PIN:   return 32'(bus.pend_in);
      S_ALM:   return 32'(bus.alarm);
      default: return 32'hdead_beef;
    endcase
  endfunction

  function automatic void sb_push(input int unsigned off, input int sig, input logic [31:0] val, input string tag);
    sb.push_back('{base + off, sig, val, tag});
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check_eq(e.tag, sample(e.sig), e.val);
    end
  end

  task automatic at_neg(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.queueUp = '0; bus.queueDown = '0; bus.queueinside = '0;
    bus.door_hold = 1'b0; bus.fault = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_cur", 32'(bus.cur_floor), 32'h1);
    check_eq("rst_moving", 32'(bus.moving), 32'h0);
    check_eq("rst_door", 32'(bus.door_open), 32'h0);
    check_eq("rst_alarm", 32'(bus.alarm), 32'h0);
    check_eq("rst_pend", 32'({bus.pend_up, bus.pend_down, bus.pend_in}), 32'h0);
    check_eq("rst_dir", 32'({bus.dir_up, bus.dir_down}), 32'h0);
    at_neg(2);
    rst = 1'b0;
    at_neg(1);

    // hall request at the car's own floor opens the door without moving; masked while open
    base = cyc;
    bus.queueUp = 4'b0001;
    sb_push(1, S_PUP, 1, "own_pend");
    sb_push(2, S_DOOR, 1, "own_door");
    sb_push(2, S_PUP, 0, "own_clear");
    sb_push(2, S_MOV, 0, "own_nomove");
    sb_push(4, S_PUP, 0, "own_masked");
    sb_push(4, S_DOOR, 1, "own_door_hi");
    sb_push(5, S_DOOR, 0, "own_door_lo");
    sb_push(5, S_CUR, 1, "own_cur");
    at_neg(1); bus.queueUp = '0;
    at_neg(2); bus.queueUp = 4'b0001;
    at_neg(1); bus.queueUp = '0;
    at_neg(3);

    // up-hall at 1 and cabin 3: stop at 1, continue to the top
    base = cyc;
    bus.queueUp = 4'b0010; bus.queueinside = 4'b1000;
    sb_push(1, S_PUP, 4'b0010, "s2_pend_up");
    sb_push(1, S_PIN, 4'b1000, "s2_pend_in");
    sb_push(5, S_CUR, 4'b0001, "s2_cur_before");
    sb_push(6, S_CUR, 4'b0010, "s2_cur_f1");
    sb_push(6, S_DOOR, 1, "s2_door_f1");
    sb_push(6, S_PUP, 0, "s2_up_clr");
    sb_push(9, S_DOOR, 0, "s2_door_f1_lo");
    sb_push(10, S_MOV, 1, "s2_resume");
    sb_push(14, S_CUR, 4'b0100, "s2_cur_f2");
    sb_push(14, S_MOV, 1, "s2_pass_f2");
    sb_push(18, S_CUR, 4'b1000, "s2_cur_f3");
    sb_push(18, S_DOOR, 1, "s2_door_f3");
    sb_push(18, S_PIN, 0, "s2_in_clr");
    sb_push(21, S_DOOR, 0, "s2_door_f3_lo");
    at_neg(1); bus.queueUp = '0; bus.queueinside = '0;
    at_neg(22);

    // reposition to floor 2
    base = cyc;
    bus.queueinside = 4'b0100;
    sb_push(2, S_DN, 1, "s3a_dir_dn");
    sb_push(6, S_CUR, 4'b0100, "s3a_cur");
    sb_push(6, S_DOOR, 1, "s3a_door");
    at_neg(1); bus.queueinside = '0;
    at_neg(9);

    // moving 2->3 for cabin 3, down-hall at 1 arrives mid-move
    base = cyc;
    bus.queueinside = 4'b1000;
    sb_push(2, S_UP, 1, "s3_dir_up");
    sb_push(4, S_PDN, 4'b0010, "s3_pend_dn");
    sb_push(6, S_CUR, 4'b1000, "s3_cur_f3");
    sb_push(6, S_DOOR, 1, "s3_door_f3");
    sb_push(6, S_PDN, 4'b0010, "s3_dn_kept");
    sb_push(10, S_DN, 1, "s3_dir_dn");
    sb_push(14, S_CUR, 4'b0100, "s3_cur_f2");
    sb_push(18, S_CUR, 4'b0010, "s3_cur_f1");
    sb_push(18, S_DOOR, 1, "s3_door_f1");
    sb_push(18, S_PDN, 0, "s3_dn_clr");
    sb_push(21, S_DOOR, 0, "s3_door_lo");
    at_neg(1); bus.queueinside = '0;
    at_neg(2); bus.queueDown = 4'b0010;
    at_neg(1); bus.queueDown = '0;
    at_neg(19);

    // door hold at floor 1
    base = cyc;
    bus.queueinside = 4'b0010;
    sb_push(2, S_PIN, 0, "ap_in_clr");
    sb_push(2, S_DOOR, 1, "ap_door_open");
`ifdef ELEV_ANTI_PINCH_EN
    sb_push(8, S_DOOR, 1, "ap_held");
    sb_push(14, S_DOOR, 1, "ap_after_release");
    sb_push(15, S_DOOR, 0, "ap_close");
`else
    sb_push(4, S_DOOR, 1, "ap_sched_hi");
    sb_push(5, S_DOOR, 0, "ap_sched_close");
    sb_push(8, S_DOOR, 0, "ap_ignored");
    sb_push(14, S_DOOR, 0, "ap_stays_closed");
`endif
    at_neg(1); bus.queueinside = '0;
    at_neg(1); bus.door_hold = 1'b1;
    at_neg(10); bus.door_hold = 1'b0;
    at_neg(6);

    // floor 1 -> floor 0
    base = cyc;
    bus.queueinside = 4'b0001;
    sb_push(6, S_CUR, 4'b0001, "leg0_cur");
    sb_push(6, S_DOOR, 1, "leg0_door");
    at_neg(1); bus.queueinside = '0;
    at_neg(9);

    // cabin request two floors up from floor 0
    base = cyc;
    bus.queueinside = 4'b0100;
    sb_push(1, S_PIN, 4'b0100, "s1_pend_in");
    sb_push(2, S_MOV, 1, "s1_moving");
    sb_push(5, S_CUR, 4'b0001, "s1_cur_hold");
    sb_push(6, S_CUR, 4'b0010, "s1_cur_f1");
    sb_push(9, S_CUR, 4'b0010, "s1_cur_f1_hold");
    sb_push(10, S_CUR, 4'b0100, "s1_cur_f2");
    sb_push(10, S_DOOR, 1, "s1_door");
    sb_push(10, S_PIN, 0, "s1_in_clr");
    sb_push(12, S_DOOR, 1, "s1_door_hi");
    sb_push(13, S_DOOR, 0, "s1_door_lo");
    sb_push(13, S_MOV, 0, "s1_idle");
    at_neg(1); bus.queueinside = '0;
    at_neg(14);

    // floor 2 -> floor 0, passing floor 1
    base = cyc;
    bus.queueinside = 4'b0001;
    sb_push(6, S_CUR, 4'b0010, "leg2_pass_f1");
    sb_push(6, S_MOV, 1, "leg2_moving");
    sb_push(10, S_CUR, 4'b0001, "leg2_cur_f0");
    sb_push(10, S_DOOR, 1, "leg2_door");
    at_neg(1); bus.queueinside = '0;
    at_neg(13);

    // fault two cycles into a 0->1 move
    base = cyc;
    bus.queueinside = 4'b0010;
    sb_push(2, S_MOV, 1, "flt_moving");
    sb_push(4, S_PIN, 4'b0010, "flt_pend_pre");
    sb_push(5, S_ALM, 1, "flt_alarm");
    sb_push(5, S_MOV, 0, "flt_stop");
    sb_push(5, S_PIN, 0, "flt_pend_clr");
    sb_push(5, S_CUR, 4'b0001, "flt_cur");
    sb_push(5, S_DOOR, 0, "flt_door");
    sb_push(7, S_PUP, 0, "flt_ignored");
    sb_push(8, S_ALM, 1, "flt_alarm_hold");
    sb_push(9, S_ALM, 0, "flt_release");
    sb_push(11, S_MOV, 0, "flt_idle");
    sb_push(11, S_CUR, 4'b0001, "flt_cur_idle");
    at_neg(1); bus.queueinside = '0;
    at_neg(3); bus.fault = 1'b1;
    at_neg(2); bus.queueUp = 4'b1000;
    at_neg(1); bus.queueUp = '0;
    at_neg(1); bus.fault = 1'b0;
    at_neg(4);

    // asynchronous reset in the middle of a move
    bus.queueinside = 4'b1000;
    at_neg(1); bus.queueinside = '0;
    at_neg(3);
    check_eq("arst_pre_moving", 32'(bus.moving), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_moving", 32'(bus.moving), 32'h0);
    check_eq("arst_dir_up", 32'(bus.dir_up), 32'h0);
    check_eq("arst_pend_in", 32'(bus.pend_in), 32'h0);
    check_eq("arst_cur", 32'(bus.cur_floor), 32'h1);
    at_neg(1); rst = 1'b0;
    at_neg(3);
    check_eq("arst_idle", 32'(bus.moving), 32'h0);

    check_eq("sb_drain", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
